// File: rtl/control_contador.sv
// -----------------------------------------------------------------------------
// control_contador
// Turns the debounced push-button levels into single-cycle command pulses for
// the event counter (Contador). It adds press-and-hold auto-repeat, a lockout
// when buttons are pressed together, and optional saturation at the counter
// limits. It replaces the bare edge detector between Rebote and Contador.
//
// State table
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   REPOSO     | idle, waiting for a fresh button press
//   PRESION    | one direction pressed, counting toward auto-repeat
//   REPETICION | auto-repeat active, one pulse every T_REP cycles
//   BLOQUEO    | lockout, nothing issued until every button is released
//
// Parameters
//   N       counter width (width of Q)
//   T_HOLD  cycles held after the first pulse before auto-repeat (>= 2)
//   T_REP   cycles between auto-repeat pulses (>= 2)
//   SATURAR 0 = counter wraps, 1 = no increment at all-ones / decrement at zero
//
// Ports
//   clk        system clock (10 MHz domain)
//   rst        synchronous active-high reset
//   btn_inc    debounced increment button level
//   btn_dec    debounced decrement button level
//   btn_clr    debounced clear button level
//   Q          current counter value, only used for saturation
//   en         one-cycle count-enable pulse
//   arriba     count direction (1 = up), held between accepted presses
//   clr        one-cycle clear pulse
//   repitiendo high while auto-repeat is active
//   limite     one-cycle pulse when saturation swallowed a count pulse
// -----------------------------------------------------------------------------
module control_contador #(
  parameter int N       = 8,
  parameter int T_HOLD  = 5_000_000,
  parameter int T_REP   = 1_000_000,
  parameter bit SATURAR = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_inc,
  input  logic         btn_dec,
  input  logic         btn_clr,
  input  logic [N-1:0] Q,
  output logic         en,
  output logic         arriba,
  output logic         clr,
  output logic         repitiendo,
  output logic         limite
);

  localparam int T_MAX = (T_HOLD > T_REP) ? T_HOLD : T_REP;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] HOLD_TC = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] REP_TC  = TW'(T_REP - 1);

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    PRESION    = 2'd1,
    REPETICION = 2'd2,
    BLOQUEO    = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  logic prev_inc_q;
  logic prev_dec_q;
  logic prev_clr_q;

  logic inc_rise;
  logic dec_rise;
  logic clr_rise;
  logic btn_act;
  logic btn_opp;
  logic all_low;

  logic pulse_req;
  logic clr_req;
  logic arriba_d;
  logic sat_hit;
  logic en_d;
  logic clr_d;
  logic lim_d;
  logic rep_d;

  // Previous-level registers reset to 1 so a button held through reset is
  // ignored until it has been released and pressed again.
  assign inc_rise = btn_inc & ~prev_inc_q;
  assign dec_rise = btn_dec & ~prev_dec_q;
  assign clr_rise = btn_clr & ~prev_clr_q;

  // While a press is being tracked, arriba holds the latched direction, so it
  // also tells which button is the active one.
  assign btn_act = arriba ? btn_inc : btn_dec;
  assign btn_opp = arriba ? btn_dec : btn_inc;
  assign all_low = ~(btn_inc | btn_dec | btn_clr);

  // ---------------------------------------------------------------------------
  // State, timer and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REPOSO;
      timer_q    <= '0;
      prev_inc_q <= 1'b1;
      prev_dec_q <= 1'b1;
      prev_clr_q <= 1'b1;
      en         <= 1'b0;
      arriba     <= 1'b1;
      clr        <= 1'b0;
      repitiendo <= 1'b0;
      limite     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      prev_inc_q <= btn_inc;
      prev_dec_q <= btn_dec;
      prev_clr_q <= btn_clr;
      en         <= en_d;
      arriba     <= arriba_d;
      clr        <= clr_d;
      repitiendo <= rep_d;
      limite     <= lim_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, timer and command requests
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    arriba_d  = arriba;
    pulse_req = 1'b0;
    clr_req   = 1'b0;

    case (state_q)
      REPOSO: begin
        if (clr_rise) begin
          clr_req = 1'b1;
          state_d = BLOQUEO;
        end else if (inc_rise && dec_rise) begin
          state_d = BLOQUEO;
        end else if (inc_rise) begin
          pulse_req = 1'b1;
          arriba_d  = 1'b1;
          state_d   = PRESION;
        end else if (dec_rise) begin
          pulse_req = 1'b1;
          arriba_d  = 1'b0;
          state_d   = PRESION;
        end
      end

      PRESION, REPETICION: begin
        // Exit conditions win over a pulse that would fall due this cycle.
        if (!btn_act) begin
          state_d = REPOSO;
        end else if (btn_opp) begin
          state_d = BLOQUEO;
        end else if (clr_rise) begin
          clr_req = 1'b1;
          state_d = BLOQUEO;
        end else if (timer_q == ((state_q == PRESION) ? HOLD_TC : REP_TC)) begin
          pulse_req = 1'b1;
          state_d   = REPETICION;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      BLOQUEO: begin
        if (all_low) begin
          state_d = REPOSO;
        end
      end

      default: begin
        state_d = REPOSO;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output next-values
  // ---------------------------------------------------------------------------
  // Saturation only swaps en for limite; the state machine advances exactly
  // as if the pulse had gone out, so repeat timing is unaffected.
  always_comb begin
    sat_hit = SATURAR && (arriba_d ? (Q == {N{1'b1}}) : (Q == {N{1'b0}}));
    en_d    = pulse_req && !sat_hit;
    lim_d   = pulse_req && sat_hit;
    clr_d   = clr_req;
    rep_d   = (state_d == REPETICION);
  end

endmodule

// File: tb/tb_control_contador.sv
module tb_control_contador;

  localparam int N  = 4;
  localparam int TH = 8;
  localparam int TR = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_inc;
  logic         btn_dec;
  logic         btn_clr;
  logic [N-1:0] q;

  logic en0, arriba0, clr0, rep0, lim0;
  logic en1, arriba1, clr1, rep1, lim1;

  control_contador #(.N(N), .T_HOLD(TH), .T_REP(TR), .SATURAR(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
    .Q(q), .en(en0), .arriba(arriba0), .clr(clr0), .repitiendo(rep0), .limite(lim0)
  );

  control_contador #(.N(N), .T_HOLD(TH), .T_REP(TR), .SATURAR(1'b1)) u_sat (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
    .Q(q), .en(en1), .arriba(arriba1), .clr(clr1), .repitiendo(rep1), .limite(lim1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int en_seen;
  int lim_seen;

  // Reference model: tracks how long the current press has lasted and derives
  // the pulse schedule arithmetically (first pulse at press, then at
  // T_HOLD, T_HOLD+T_REP, ... cycles into the hold).
  typedef enum {M_IDLE, M_HOLD, M_LOCK} mode_t;
  mode_t    m_mode;
  bit       m_dir;
  int       m_n;
  bit       p_i, p_d, p_c;
  bit [4:0] exp0, exp1;   // {en, arriba, clr, repitiendo, limite}

  task automatic model_step(input bit r, input bit i, input bit d, input bit c,
                            input logic [N-1:0] qv);
    bit ie, de, ce, pulse, clrp, rep, lim_hit;
    pulse = 0;
    clrp  = 0;
    if (r) begin
      m_mode = M_IDLE;
      m_dir  = 1;
      m_n    = 0;
      p_i = 1; p_d = 1; p_c = 1;
      exp0 = 5'b01000;
      exp1 = 5'b01000;
    end else begin
      ie = i && !p_i;
      de = d && !p_d;
      ce = c && !p_c;
      case (m_mode)
        M_IDLE: begin
          if (ce) begin clrp = 1; m_mode = M_LOCK; end
          else if (ie && de) m_mode = M_LOCK;
          else if (ie) begin pulse = 1; m_dir = 1; m_mode = M_HOLD; m_n = 0; end
          else if (de) begin pulse = 1; m_dir = 0; m_mode = M_HOLD; m_n = 0; end
        end
        M_HOLD: begin
          m_n++;
          if (!(m_dir ? i : d)) m_mode = M_IDLE;
          else if (m_dir ? d : i) m_mode = M_LOCK;
          else if (ce) begin clrp = 1; m_mode = M_LOCK; end
          else if (m_n >= TH && ((m_n - TH) % TR) == 0) pulse = 1;
        end
        default: begin
          if (!i && !d && !c) m_mode = M_IDLE;
        end
      endcase
      p_i = i; p_d = d; p_c = c;
      rep     = (m_mode == M_HOLD) && (m_n >= TH);
      lim_hit = m_dir ? (qv == {N{1'b1}}) : (qv == {N{1'b0}});
      exp0 = {pulse, m_dir, clrp, rep, 1'b0};
      exp1 = {pulse && !lim_hit, m_dir, clrp, rep, pulse && lim_hit};
    end
  endtask

  task automatic tick(input bit r, input bit i, input bit d, input bit c,
                      input logic [N-1:0] qv, input string tag);
    rst = r; btn_inc = i; btn_dec = d; btn_clr = c; q = qv;
    @(posedge clk);
    model_step(r, i, d, c, qv);
    #1;
    total++;
    assert ({en0, arriba0, clr0, rep0, lim0} === exp0)
      else begin
        bad++;
        $error("FAIL %s wrap: got {en,arriba,clr,rep,lim}=%b expected %b", tag,
               {en0, arriba0, clr0, rep0, lim0}, exp0);
      end
    total++;
    assert ({en1, arriba1, clr1, rep1, lim1} === exp1)
      else begin
        bad++;
        $error("FAIL %s sat: got {en,arriba,clr,rep,lim}=%b expected %b", tag,
               {en1, arriba1, clr1, rep1, lim1}, exp1);
      end
    if (en0 === 1'b1) en_seen++;
    if (lim1 === 1'b1) lim_seen++;
  endtask

  task automatic check_count(input int got, input int want, input string tag);
    total++;
    assert (got === want)
      else begin
        bad++;
        $error("FAIL %s: got %0d pulses expected %0d", tag, got, want);
      end
  endtask

  initial begin
    bit ri, rd, rc, rr;
    logic [N-1:0] rq;

    // reset and settle
    tick(1, 0, 0, 0, 4'h5, "reset");
    tick(1, 0, 0, 0, 4'h5, "reset");
    tick(0, 0, 0, 0, 4'h5, "idle");
    tick(0, 0, 0, 0, 4'h5, "idle");

    // 1: short press, single pulse
    en_seen = 0;
    for (int k = 0; k < 3; k++) tick(0, 1, 0, 0, 4'h5, "t1_short");
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 0, 4'h5, "t1_rel");
    check_count(en_seen, 1, "t1_en_count");

    // 2: long press, auto-repeat
    en_seen = 0;
    for (int k = 0; k < 20; k++) tick(0, 1, 0, 0, 4'h5, "t2_hold");
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 0, 4'h5, "t2_rel");
    check_count(en_seen, 4, "t2_en_count");

    // 3: simultaneous press locks out, then a clean decrement
    en_seen = 0;
    for (int k = 0; k < 3; k++) tick(0, 1, 1, 0, 4'h5, "t3_both");
    for (int k = 0; k < 2; k++) tick(0, 0, 0, 0, 4'h5, "t3_rel");
    for (int k = 0; k < 2; k++) tick(0, 0, 1, 0, 4'h5, "t3_dec");
    for (int k = 0; k < 2; k++) tick(0, 0, 0, 0, 4'h5, "t3_rel2");
    check_count(en_seen, 1, "t3_en_count");

    // 4: clear during a hold
    en_seen = 0;
    for (int k = 0; k < 12; k++) tick(0, 1, 0, (k >= 5 && k <= 7), 4'h5, "t4_hold_clr");
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 0, 4'h5, "t4_rel");
    check_count(en_seen, 1, "t4_en_count");

    // 5: saturation at the limits
    lim_seen = 0;
    for (int k = 0; k < 2; k++) tick(0, 1, 0, 0, 4'hF, "t5_inc_at_max");
    for (int k = 0; k < 2; k++) tick(0, 0, 0, 0, 4'hF, "t5_rel");
    for (int k = 0; k < 2; k++) tick(0, 0, 1, 0, 4'hF, "t5_dec_at_max");
    for (int k = 0; k < 2; k++) tick(0, 0, 0, 0, 4'h0, "t5_rel2");
    for (int k = 0; k < 2; k++) tick(0, 0, 1, 0, 4'h0, "t5_dec_at_zero");
    for (int k = 0; k < 2; k++) tick(0, 0, 0, 0, 4'h0, "t5_rel3");
    check_count(lim_seen, 2, "t5_limite_count");

    // 6: button held through reset, then reset during auto-repeat
    en_seen = 0;
    for (int k = 0; k < 2; k++) tick(1, 1, 0, 0, 4'h5, "t6_rst_held");
    for (int k = 0; k < 5; k++) tick(0, 1, 0, 0, 4'h5, "t6_held_after");
    check_count(en_seen, 0, "t6_no_en_after_rst");
    for (int k = 0; k < 2; k++) tick(0, 0, 0, 0, 4'h5, "t6_rel");
    for (int k = 0; k < 10; k++) tick(0, 1, 0, 0, 4'h5, "t6_repress");
    tick(1, 1, 0, 0, 4'h5, "t6_rst_in_rep");
    for (int k = 0; k < 3; k++) tick(0, 1, 0, 0, 4'h5, "t6_after_rst");
    for (int k = 0; k < 2; k++) tick(0, 0, 0, 0, 4'h5, "t6_rel2");

    // random buttons with persistence so holds reach auto-repeat
    ri = 0; rd = 0; rc = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0)  ri = !ri;
      if ($urandom_range(0, 13) == 0) rd = !rd;
      if ($urandom_range(0, 29) == 0) rc = !rc;
      rr = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0:       rq = 4'h0;
        1:       rq = 4'hF;
        default: rq = N'($urandom);
      endcase
      tick(rr, ri, rd, rc, rq, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_contador.md
Name: control_contador

Overview:
Sequencing controller for the 8-bit event counter (Contador) driven by the debounced push-buttons. It takes up to three debounced button levels (increment, decrement, clear) and generates single-cycle enable/direction/clear commands. It adds press-and-hold auto-repeat, simultaneous-press lockout and optional saturation at the counter limits. It sits between the Rebote instances and the counter, replacing the bare edge detector.

Parameters:
N, 8, counter width; width of the Q feedback input.
T_HOLD, 5_000_000, cycles a button must stay held after the first pulse before auto-repeat starts (500 ms at 10 MHz); must be >= 2.
T_REP, 1_000_000, cycles between auto-repeat pulses (100 ms at 10 MHz); must be >= 2.
SATURAR, 0, 0 = commands issued regardless of Q (counter wraps); 1 = suppress increment at all-ones and decrement at zero.

Ports:
clk  input  1  system clock (10 MHz domain)
rst  input  1  synchronous active-high reset
btn_inc  input  1  debounced increment button level
btn_dec  input  1  debounced decrement button level
btn_clr  input  1  debounced clear button level
Q  input  N  current counter value, used for saturation only
en  output  1  one-cycle count-enable pulse to the counter
arriba  output  1  direction (1 = up, 0 = down); held stable, valid whenever en = 1
clr  output  1  one-cycle clear pulse to the counter
repitiendo  output  1  high while in auto-repeat
limite  output  1  one-cycle pulse when a command is suppressed by saturation

Behaviour:
- All outputs are registered. Reset values:
  - en = 0, clr = 0, repitiendo = 0, limite = 0, arriba = 1.
  - State = REPOSO, timer = 0.
  - Previous-level registers = 1. A button held through reset therefore produces nothing until it is released and pressed again.
- Rising edge = level 1 this cycle and previous-level register 0. Edge at input in cycle k gives the command output in cycle k+1.
- Timer width = clog2(max(T_HOLD, T_REP)). The timer is cleared on every state entry.
- States:
  - REPOSO:
    - Priority is clr > simultaneous inc+dec > inc > dec.
    - clr rising: clr pulse -> BLOQUEO.
    - inc and dec rising in the same cycle: no pulse -> BLOQUEO.
    - inc rising: en pulse, arriba = 1 -> PRESION.
    - dec rising: en pulse, arriba = 0 -> PRESION.
  - PRESION (direction latched):
    - Timer increments each cycle.
    - Active button low -> REPOSO.
    - Opposite button high -> BLOQUEO, no pulse.
    - clr rising -> clr pulse, BLOQUEO.
    - Timer == T_HOLD-1 -> en pulse, go to REPETICION.
  - REPETICION: same exit rules as PRESION. Timer == T_REP-1 -> en pulse, timer = 0. repitiendo = 1 in this state.
  - BLOQUEO: no pulses. Go to REPOSO only when btn_inc, btn_dec and btn_clr are all low.
- Saturation (SATURAR = 1), checked in the cycle the pulse would be issued:
  - Up with Q == all ones, or down with Q == 0: en stays 0 and limite pulses instead.
  - State and timer advance as if the pulse had been sent.
- en and clr are never high in the same cycle. arriba changes only when a new press is accepted.
- Reset mid-operation: all outputs return to reset values the cycle after rst is sampled high, regardless of state.

Test Plan:
Bench uses N=4, T_HOLD=8, T_REP=4. k = first cycle the button is high.
1. btn_inc high for 3 cycles -> en=1, arriba=1 at cycle k+1 only; no further pulses; repitiendo stays 0.
2. btn_inc high for 20 cycles (k..k+19) -> en pulses at k+1, k+9, k+13, k+17; repitiendo=1 from k+9 to k+20; no pulse at k+21.
3. btn_inc and btn_dec rise in the same cycle -> no en; both released, then btn_dec pressed -> one en with arriba=0.
4. btn_inc held 12 cycles, btn_clr rises at k+5 -> clr=1 at k+6 only; no en after k+1 until all buttons are released.
5. SATURAR=1, Q=4'hF, btn_inc pressed -> en=0, limite=1 at k+1. btn_dec pressed -> en=1, arriba=0. SATURAR=0 with the same stimulus -> en=1 at k+1.
6. btn_inc held through rst deassertion -> no en until released and re-pressed. rst asserted during REPETICION -> en=0, repitiendo=0 on the next cycle.
